// File: rtl/microwave_controller.sv
// Microwave oven controller: keypad time entry, start/stop/door interlock, M:SS countdown.
// Optional BLANK_LEADING_ZERO_EN blanks leading zero digits on the display.
module microwave_controller #(
    parameter int CLK_DIV         = 100,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic [9:0] keypad,
    output logic       mag_on,
    output logic [6:0] sec_ones_segs,
    output logic [6:0] sec_tens_segs,
    output logic [6:0] mins_segs
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DB_FULL   = DW'(DEBOUNCE_CYCLES);

    typedef enum logic {IDLE = 1'b0, COOK = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_mag_on;
    logic          r_start_s1, r_start_s2, r_start_s3;
    logic          r_stop_s1, r_stop_s2;
    logic          r_door_s1, r_door_s2;
    logic [9:0]    r_key_s1, r_key_s2;
    logic [9:0]    r_db_code;
    logic [DW-1:0] r_db_cnt;
    logic [DW-1:0] w_db_cnt_next;
    logic          r_armed;
    logic          w_onehot;
    logic          w_key_accept;
    logic [3:0]    w_key_digit;
    logic [3:0]    r_min, r_tens, r_ones;
    logic [3:0]    w_min_next, w_tens_next, w_ones_next;
    logic [3:0]    w_dec_min, w_dec_tens, w_dec_ones;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          w_start_fall;
    logic          w_tick;
    logic          w_time_zero;
    logic          w_dec_zero;

    // Start/stop idle high after clear so no false edge is seen on release.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_start_s1 <= 1'b1;
            r_start_s2 <= 1'b1;
            r_start_s3 <= 1'b1;
            r_stop_s1  <= 1'b1;
            r_stop_s2  <= 1'b1;
            r_door_s1  <= 1'b0;
            r_door_s2  <= 1'b0;
            r_key_s1   <= 10'd0;
            r_key_s2   <= 10'd0;
        end else begin
            r_start_s1 <= startn;
            r_start_s2 <= r_start_s1;
            r_start_s3 <= r_start_s2;
            r_stop_s1  <= stopn;
            r_stop_s2  <= r_stop_s1;
            r_door_s1  <= door_closed;
            r_door_s2  <= r_door_s1;
            r_key_s1   <= keypad;
            r_key_s2   <= r_key_s1;
        end
    end

    assign w_onehot = (r_key_s2 != 10'd0) && ((r_key_s2 & (r_key_s2 - 10'd1)) == 10'd0);

    always_comb begin
        w_db_cnt_next = DW'(1);
        if (r_key_s2 == r_db_code) begin
            w_db_cnt_next = (r_db_cnt == DB_FULL) ? DB_FULL : r_db_cnt + DW'(1);
        end
    end

    assign w_key_accept = w_onehot && r_armed && (w_db_cnt_next == DB_FULL);

    always_comb begin
        w_key_digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (r_key_s2[k]) begin
                w_key_digit = 4'(k);
            end
        end
    end

    // Re-arm only after the keypad reads empty; any accept or multi-key code disarms.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_db_code <= 10'd0;
            r_db_cnt  <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_db_code <= r_key_s2;
            r_db_cnt  <= w_db_cnt_next;
            if (r_key_s2 == 10'd0) begin
                r_armed <= 1'b1;
            end else if (w_key_accept || !w_onehot) begin
                r_armed <= 1'b0;
            end
        end
    end

    assign w_start_fall = r_start_s3 & ~r_start_s2;
    assign w_time_zero  = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_tick       = (r_state == COOK) && (r_presc == PRESC_MAX);

    always_comb begin
        w_dec_min  = r_min;
        w_dec_tens = r_tens;
        w_dec_ones = r_ones;
        if (r_ones != 4'd0) begin
            w_dec_ones = r_ones - 4'd1;
        end else if (r_tens != 4'd0) begin
            w_dec_tens = r_tens - 4'd1;
            w_dec_ones = 4'd9;
        end else begin
            w_dec_min  = r_min - 4'd1;
            w_dec_tens = 4'd5;
            w_dec_ones = 4'd9;
        end
    end

    assign w_dec_zero = (w_dec_min == 4'd0) && (w_dec_tens == 4'd0) && (w_dec_ones == 4'd0);

    always_comb begin
        w_state_next = r_state;
        w_min_next   = r_min;
        w_tens_next  = r_tens;
        w_ones_next  = r_ones;
        w_presc_next = r_presc;
        case (r_state)
            IDLE: begin
                if (w_key_accept) begin
                    w_min_next  = r_tens;
                    w_tens_next = r_ones;
                    w_ones_next = w_key_digit;
                end
                if (w_start_fall && r_door_s2 && r_stop_s2 && !w_time_zero) begin
                    w_state_next = COOK;
                    w_presc_next = '0;
                end
            end
            COOK: begin
                w_presc_next = w_tick ? '0 : r_presc + PW'(1);
                // A decrement on the same edge as stop/door-open still lands.
                if (w_tick) begin
                    w_min_next  = w_dec_min;
                    w_tens_next = w_dec_tens;
                    w_ones_next = w_dec_ones;
                end
                if (!r_door_s2 || !r_stop_s2 || (w_tick && w_dec_zero)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_state  <= IDLE;
            r_mag_on <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_mag_on <= (w_state_next == COOK);
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_min   <= 4'd0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_presc <= '0;
        end else begin
            r_min   <= w_min_next;
            r_tens  <= w_tens_next;
            r_ones  <= w_ones_next;
            r_presc <= w_presc_next;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign mag_on        = r_mag_on;
    assign sec_ones_segs = seg7(r_ones);
`ifdef BLANK_LEADING_ZERO_EN
    assign mins_segs     = (r_min == 4'd0) ? 7'h00 : seg7(r_min);
    assign sec_tens_segs = ((r_min == 4'd0) && (r_tens == 4'd0)) ? 7'h00 : seg7(r_tens);
`else
    assign mins_segs     = seg7(r_min);
    assign sec_tens_segs = seg7(r_tens);
`endif

endmodule

// File: tb/tb_microwave_controller.sv
// Randomized self-checking bench for microwave_controller against a decimal-arithmetic time model.
module tb_microwave_controller;
    localparam int CLK_DIV = 100;
    localparam int DEB     = 4;

    logic       clock = 1'b0;
    logic       clearn;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic [9:0] keypad;
    logic       mag_on;
    logic [6:0] sec_ones_segs;
    logic [6:0] sec_tens_segs;
    logic [6:0] mins_segs;

    int n_checks = 0;
    int n_errors = 0;
    int model_n  = 0;   // time as a 3-digit decimal number MTO

    microwave_controller #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clock(clock), .clearn(clearn), .startn(startn), .stopn(stopn),
        .door_closed(door_closed), .keypad(keypad), .mag_on(mag_on),
        .sec_ones_segs(sec_ones_segs), .sec_tens_segs(sec_tens_segs), .mins_segs(mins_segs)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (model %0d)", tag, got, exp, model_n);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [20:0] disp_of(input int n);
        logic [6:0] m_s, t_s, o_s;
        m_s = seg_of(n / 100);
        t_s = seg_of((n / 10) % 10);
        o_s = seg_of(n % 10);
`ifdef BLANK_LEADING_ZERO_EN
        if (n / 100 == 0) m_s = 7'h00;
        if (n / 10 == 0)  t_s = 7'h00;
`endif
        return {m_s, t_s, o_s};
    endfunction

    // One second off: borrow across the minute boundary costs 41 in MTO form (1:00 -> 0:59).
    function automatic int model_dec(input int n);
        return (n % 100 == 0) ? n - 41 : n - 1;
    endfunction

    function automatic int secs_of(input int n);
        return (n / 100) * 60 + (n % 100);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_disp(input string tag);
        chk(tag, {11'd0, mins_segs, sec_tens_segs, sec_ones_segs}, {11'd0, disp_of(model_n)});
    endtask

    task automatic model_cook(input int k);
        for (int i = 0; i < k; i++) model_n = model_dec(model_n);
    endtask

    task automatic press_key(input int d, input int hold);
        keypad = 10'd1 << d;
        cyc(hold);
        keypad = 10'd0;
        cyc(10);
        if (hold >= DEB) model_n = (model_n % 100) * 10 + d;
        $display("key %0d hold %0d -> model %0d", d, hold, model_n);
        chk_disp("key_entry");
    endtask

    task automatic press_pair(input int a, input int b, input int alone);
        keypad = 10'd1 << a;
        cyc(alone);
        keypad = keypad | (10'd1 << b);
        cyc(20);
        keypad = 10'd0;
        cyc(10);
        if (alone >= DEB) model_n = (model_n % 100) * 10 + a;
        $display("pair %0d+%0d alone %0d -> model %0d", a, b, alone, model_n);
        chk_disp("pair_entry");
    endtask

    task automatic do_start(input logic exp_on);
        startn = 1'b0;
        cyc(2);
        chk("start_early", {31'd0, mag_on}, 32'd0);
        cyc(1);
        chk("start_mag", {31'd0, mag_on}, {31'd0, exp_on});
        startn = 1'b1;
        $display("start expect mag_on %0d got %0d", exp_on, mag_on);
    endtask

    // Called on the negedge right after the COOK-entry edge; optional key is pressed mid-cook.
    task automatic cook_wait(input int ncyc, input int keyd);
        if (keyd >= 0) begin
            keypad = 10'd1 << keyd;
            cyc(10);
            keypad = 10'd0;
            cyc(ncyc - 10);
        end else begin
            cyc(ncyc);
        end
    endtask

    task automatic cook_halt(input int k, input int mode, input int keyd);
        cook_wait(k * CLK_DIV, keyd);
        cyc(10);
        if (mode == 0) door_closed = 1'b0;
        else stopn = 1'b0;
        cyc(2);
        chk("halt_early", {31'd0, mag_on}, 32'd1);
        cyc(1);
        chk("halt_mag", {31'd0, mag_on}, 32'd0);
        model_cook(k);
        chk_disp("halt_disp");
        $display("halt after %0d s mode %0d -> model %0d", k, mode, model_n);
    endtask

    task automatic run_to_end(input int s, input int keyd);
        cook_wait(s * CLK_DIV - 1, keyd);
        chk("end_before", {31'd0, mag_on}, 32'd1);
        cyc(1);
        chk("end_mag", {31'd0, mag_on}, 32'd0);
        model_cook(s);
        chk_disp("end_disp");
        $display("cooked %0d s to end -> model %0d", s, model_n);
    endtask

    task automatic release_halt();
        door_closed = 1'b1;
        stopn = 1'b1;
        cyc(5);
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        #1;
        model_n = 0;
        chk("clear_mag", {31'd0, mag_on}, 32'd0);
        chk_disp("clear_disp");
        cyc(2);
        clearn = 1'b1;
        cyc(3);
        $display("clear");
    endtask

    initial begin
        int s, k, a, b, mode, keyd;
        clearn = 1'b0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; keypad = 10'd0;
        cyc(3);
        chk("reset_mag", {31'd0, mag_on}, 32'd0);
        chk("reset_disp", {11'd0, mins_segs, sec_tens_segs, sec_ones_segs}, {11'd0, 7'h3F, 7'h3F, 7'h3F});
        clearn = 1'b1;
        cyc(3);

        do_start(1'b0);   // 0:00 never starts

        // exact key latency: visible on edge 2+DEB
        keypad = 10'd1 << 1;
        cyc(DEB + 1);
        chk_disp("key_lat_before");
        cyc(1);
        model_n = 1;
        chk_disp("key_lat_after");
        cyc(10);
        keypad = 10'd0;
        cyc(10);
        press_key(3, 50);
        press_key(0, 50);
        chk("disp_130", {11'd0, mins_segs, sec_tens_segs, sec_ones_segs}, {11'd0, 7'h06, 7'h4F, 7'h3F});

        // door interlock, then full 90 s cook with a redundant start mid-cook
        door_closed = 1'b0; cyc(5);
        do_start(1'b0);
        door_closed = 1'b1; cyc(5);
        do_start(1'b1);
        cyc(10);
        startn = 1'b0;
        cyc(5);
        chk("start_in_cook", {31'd0, mag_on}, 32'd1);
        startn = 1'b1;
        cyc(CLK_DIV - 16);
        chk_disp("first_dec_before");
        cyc(1);
        model_cook(1);
        chk_disp("first_dec_after");
        run_to_end(89, -1);

        // door open mid-cook then resume
        press_key(2, 10); press_key(0, 10);
        do_start(1'b1);
        cook_halt(5, 0, -1);
        release_halt();
        do_start(1'b1);
        run_to_end(secs_of(model_n), -1);

        // stop held, start ignored while stopped, key ignored while cooking
        press_key(1, 10); press_key(5, 10);
        do_start(1'b1);
        cook_halt(5, 1, 7);
        do_start(1'b0);
        release_halt();
        do_start(1'b1);
        cook_halt(2, 0, -1);
        release_halt();

        // entry of 8:51 then clear
        do_clear();
        press_key(8, 10); press_key(5, 10); press_key(1, 10);
        chk("disp_851", {11'd0, mins_segs, sec_tens_segs, sec_ones_segs}, {11'd0, 7'h7F, 7'h6D, 7'h06});
        do_clear();

        // overlapping keys
        press_pair(5, 1, 50);
        press_pair(5, 1, 3);

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 5) == 0) do_clear();
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                a = $urandom_range(0, 9);
                if ($urandom_range(0, 3) == 0) begin
                    b = (a + $urandom_range(1, 9)) % 10;
                    press_pair(a, b, $urandom_range(2, 8));
                end else begin
                    press_key(a, $urandom_range(2, 8));
                end
            end
            if (model_n == 0) begin
                do_start(1'b0);
            end else begin
                do_start(1'b1);
                s = secs_of(model_n);
                keyd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : -1;
                if (s <= 6) begin
                    run_to_end(s, keyd);
                end else begin
                    k = $urandom_range(1, 5);
                    mode = $urandom_range(0, 1);
                    cook_halt(k, mode, keyd);
                    release_halt();
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
